tile_read_streamer: RTL and testbench

TILE_READ_STREAMER -- requirements
Module: tile_read_streamer

---
 rtl/tile_read_streamer_if.sv | 45 ++++
 rtl/tile_read_streamer.sv | 176 +++++++++++++++++
 tb/tb_tile_read_streamer.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_read_streamer_if.sv
// Request, memory-read and row-output signals of the tile read streamer.
// The streamer connects through the slave modport; the requester/memory side uses master.
interface tile_read_streamer_if #(
    parameter int SYS_ARRAY_SIZE = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 32
);
    localparam int ROW_W = SYS_ARRAY_SIZE * DATA_WIDTH;
    localparam int CNT_W = $clog2(SYS_ARRAY_SIZE + 1);

    logic                  valid_i;
    logic                  ready_o;
    logic [ADDR_WIDTH-1:0] addr_a_i;
    logic [ADDR_WIDTH-1:0] addr_b_i;
    logic [ADDR_WIDTH-1:0] stride_a_i;
    logic [ADDR_WIDTH-1:0] stride_b_i;
    logic [CNT_W-1:0]      n_i;
    logic                  last_req_i;
    logic                  stall_i;
    logic [ROW_W-1:0]      a_o;
    logic [ROW_W-1:0]      b_o;
    logic                  valid_o;
    logic                  last_o;
    logic                  busy_o;
    logic                  en_a_o;
    logic                  en_b_o;
    logic [ADDR_WIDTH-1:0] addr_a_o;
    logic [ADDR_WIDTH-1:0] addr_b_o;
    logic [ROW_W-1:0]      rdata_a_i;
    logic [ROW_W-1:0]      rdata_b_i;

    modport slave (
        input  valid_i, addr_a_i, addr_b_i, stride_a_i, stride_b_i, n_i, last_req_i,
               stall_i, rdata_a_i, rdata_b_i,
        output ready_o, a_o, b_o, valid_o, last_o, busy_o, en_a_o, en_b_o,
               addr_a_o, addr_b_o
    );

    modport master (
        output valid_i, addr_a_i, addr_b_i, stride_a_i, stride_b_i, n_i, last_req_i,
               stall_i, rdata_a_i, rdata_b_i,
        input  ready_o, a_o, b_o, valid_o, last_o, busy_o, en_a_o, en_b_o,
               addr_a_o, addr_b_o
    );
endinterface

// File: rtl/tile_read_streamer.sv
// Streams the rows of an A/B tile pair from two memories into a systolic array,
// with a registered output stage and a one-entry skid buffer absorbing stalls.
module tile_read_streamer #(
    parameter int SYS_ARRAY_SIZE = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 32
) (
    input logic clk_i,
    input logic rst_i,
    tile_read_streamer_if.slave bus
);
    localparam int ROW_W = SYS_ARRAY_SIZE * DATA_WIDTH;
    localparam int CNT_W = $clog2(SYS_ARRAY_SIZE + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                state;
    logic [CNT_W-1:0]      row_cnt;
    logic [CNT_W-1:0]      n_eff_q;
    logic [CNT_W-1:0]      n_eff_in;
    logic [ADDR_WIDTH-1:0] addr_a_q;
    logic [ADDR_WIDTH-1:0] addr_b_q;
    logic [ADDR_WIDTH-1:0] stride_a_q;
    logic [ADDR_WIDTH-1:0] stride_b_q;
    logic                  last_req_q;
    logic                  pend;
    logic                  pend_last;
    logic                  out_valid;
    logic                  out_last;
    logic [ROW_W-1:0]      out_a;
    logic [ROW_W-1:0]      out_b;
    logic                  skid_valid;
    logic                  skid_last;
    logic [ROW_W-1:0]      skid_a;
    logic [ROW_W-1:0]      skid_b;
    logic [ROW_W-1:0]      lane_mask;
    logic [ROW_W-1:0]      in_a;
    logic [ROW_W-1:0]      in_b;
    logic                  pipe_empty;
    logic                  ready;
    logic                  accept;
    logic                  issue;
    logic                  issue_last;
    logic                  consume;
    logic                  drain_done;

    assign n_eff_in   = (bus.n_i > CNT_W'(SYS_ARRAY_SIZE)) ? CNT_W'(SYS_ARRAY_SIZE) : bus.n_i;
    assign pipe_empty = !pend && !out_valid && !skid_valid;
    assign ready      = (state == IDLE) && pipe_empty;
    assign accept     = !rst_i && bus.valid_i && ready;
    assign issue      = !rst_i && !bus.stall_i &&
                        ((accept && (n_eff_in != '0)) || (state == ISSUE));
    assign consume    = out_valid && !bus.stall_i;
    // Pipeline will be empty after this edge, so DRAIN can hand over to IDLE now.
    assign drain_done = !pend && !skid_valid && (!out_valid || consume);

    always_comb begin
        issue_last = 1'b0;
        if (state == ISSUE)
            issue_last = last_req_q && (row_cnt == n_eff_q - CNT_W'(1));
        else
            issue_last = bus.last_req_i && (n_eff_in == CNT_W'(1));
    end

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < SYS_ARRAY_SIZE; i++)
            if (i < int'(n_eff_q))
                lane_mask[i*DATA_WIDTH +: DATA_WIDTH] = '1;
    end

    assign in_a = bus.rdata_a_i & lane_mask;
    assign in_b = bus.rdata_b_i & lane_mask;

    assign bus.ready_o  = ready;
    assign bus.busy_o   = (state != IDLE);
    assign bus.en_a_o   = issue;
    assign bus.en_b_o   = issue;
    assign bus.addr_a_o = (state == IDLE) ? bus.addr_a_i : addr_a_q;
    assign bus.addr_b_o = (state == IDLE) ? bus.addr_b_i : addr_b_q;
    assign bus.a_o      = out_a;
    assign bus.b_o      = out_b;
    assign bus.valid_o  = out_valid;
    assign bus.last_o   = out_last;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            row_cnt    <= '0;
            n_eff_q    <= '0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            stride_a_q <= '0;
            stride_b_q <= '0;
            last_req_q <= 1'b0;
            pend       <= 1'b0;
            pend_last  <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_a      <= '0;
            out_b      <= '0;
            skid_valid <= 1'b0;
            skid_last  <= 1'b0;
            skid_a     <= '0;
            skid_b     <= '0;
        end else begin
            pend      <= issue;
            pend_last <= issue && issue_last;

            case (state)
                IDLE: begin
                    if (accept) begin
                        n_eff_q    <= n_eff_in;
                        stride_a_q <= bus.stride_a_i;
                        stride_b_q <= bus.stride_b_i;
                        last_req_q <= bus.last_req_i;
                        if (n_eff_in != '0) begin
                            if (bus.stall_i) begin
                                row_cnt  <= '0;
                                addr_a_q <= bus.addr_a_i;
                                addr_b_q <= bus.addr_b_i;
                                state    <= ISSUE;
                            end else begin
                                row_cnt  <= CNT_W'(1);
                                addr_a_q <= bus.addr_a_i + bus.stride_a_i;
                                addr_b_q <= bus.addr_b_i + bus.stride_b_i;
                                state    <= (n_eff_in == CNT_W'(1)) ? DRAIN : ISSUE;
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (!bus.stall_i) begin
                        addr_a_q <= addr_a_q + stride_a_q;
                        addr_b_q <= addr_b_q + stride_b_q;
                        row_cnt  <= row_cnt + CNT_W'(1);
                        if (row_cnt == n_eff_q - CNT_W'(1))
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_done)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Output refills from the skid first so row order is kept.
            if (!out_valid || consume) begin
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    out_a      <= skid_a;
                    out_b      <= skid_b;
                    out_last   <= skid_last;
                    skid_valid <= pend;
                    skid_a     <= in_a;
                    skid_b     <= in_b;
                    skid_last  <= pend_last;
                end else if (pend) begin
                    out_valid <= 1'b1;
                    out_a     <= in_a;
                    out_b     <= in_b;
                    out_last  <= pend_last;
                end else begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            end else if (pend) begin
                skid_valid <= 1'b1;
                skid_a     <= in_a;
                skid_b     <= in_b;
                skid_last  <= pend_last;
            end
        end
    end
endmodule

// File: tb/tb_tile_read_streamer.sv
// Randomised and directed bench for tile_read_streamer against a queue-based
// model of the addresses and row beats each accepted tile must produce.
module tb_tile_read_streamer;
    localparam int SIZE = 8;
    localparam int DW   = 8;
    localparam int AW   = 32;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   ff_mode = 1'b0;

    logic [31:0] addrq_a[$];
    logic [31:0] addrq_b[$];
    beat_t       beatq[$];
    logic [31:0] addr_log[$];
    beat_t       beat_log[$];
    int          beat_cyc[$];
    int          acc_cyc = 0;
    int          acc_count = 0;

    bit          held = 1'b0;
    logic [63:0] held_a;
    logic [63:0] held_b;
    logic        held_last;
    logic [63:0] nxt_a;
    logic [63:0] nxt_b;

    tile_read_streamer_if #(.SYS_ARRAY_SIZE(SIZE), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    tile_read_streamer #(.SYS_ARRAY_SIZE(SIZE), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] mem_row(input logic [31:0] addr, input bit side_b);
        logic [31:0] h;
        if (ff_mode) return '1;
        h = addr ^ (side_b ? 32'h5A17_C3E9 : 32'h0F1E_2D3C);
        return {h * 32'h9E37_79B1, ~h ^ 32'h1357_9BDF};
    endfunction

    function automatic logic [63:0] lane_keep(input int ne);
        if (ne >= SIZE) return '1;
        return (64'd1 << (DW * ne)) - 64'd1;
    endfunction

    function automatic bit model_ready();
        return beatq.size() == 0;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got unexpected event expected none (cycle %0d)", name, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Memory: data for an enabled read is presented during the following cycle.
    always @(negedge clk) begin
        nxt_a = bus.en_a_o ? mem_row(bus.addr_a_o, 1'b0) : {$urandom, $urandom};
        nxt_b = bus.en_b_o ? mem_row(bus.addr_b_o, 1'b1) : {$urandom, $urandom};
    end

    initial begin
        bus.rdata_a_i = '0;
        bus.rdata_b_i = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.rdata_a_i = nxt_a;
            bus.rdata_b_i = nxt_b;
        end
    end

    // Compare process: model expectations are built at acceptance and consumed as the DUT proceeds.
    always @(negedge clk) begin
        if (rst) begin
            addrq_a.delete();
            addrq_b.delete();
            beatq.delete();
            held = 1'b0;
        end else begin
            checkOutput("ready", 64'(bus.ready_o), 64'(model_ready()));
            checkOutput("busy", 64'(bus.busy_o), 64'(!model_ready()));
            if (bus.valid_i && model_ready()) begin
                int ne;
                ne = (int'(bus.n_i) > SIZE) ? SIZE : int'(bus.n_i);
                acc_count++;
                acc_cyc = cyc;
                for (int k = 0; k < ne; k++) begin
                    beat_t bt;
                    logic [31:0] aa;
                    logic [31:0] ab;
                    aa = bus.addr_a_i + 32'(k) * bus.stride_a_i;
                    ab = bus.addr_b_i + 32'(k) * bus.stride_b_i;
                    addrq_a.push_back(aa);
                    addrq_b.push_back(ab);
                    bt.a = mem_row(aa, 1'b0) & lane_keep(ne);
                    bt.b = mem_row(ab, 1'b1) & lane_keep(ne);
                    bt.last = bus.last_req_i && (k == ne - 1);
                    beatq.push_back(bt);
                end
            end
            checkOutput("en_ab_equal", 64'(bus.en_a_o), 64'(bus.en_b_o));
            if (bus.en_a_o) begin
                checkOutput("en_under_stall", 64'(bus.stall_i), 64'd0);
                if (addrq_a.size() == 0) begin
                    failNow("en_extra");
                end else begin
                    checkOutput("addr_a", 64'(bus.addr_a_o), 64'(addrq_a[0]));
                    checkOutput("addr_b", 64'(bus.addr_b_o), 64'(addrq_b[0]));
                    addr_log.push_back(bus.addr_a_o);
                    void'(addrq_a.pop_front());
                    void'(addrq_b.pop_front());
                end
            end
            if (held) begin
                checkOutput("hold_valid", 64'(bus.valid_o), 64'd1);
                checkOutput("hold_a", bus.a_o, held_a);
                checkOutput("hold_b", bus.b_o, held_b);
                checkOutput("hold_last", 64'(bus.last_o), 64'(held_last));
            end
            if (bus.valid_o) begin
                if (beatq.size() == 0) begin
                    failNow("beat_extra");
                    held = 1'b0;
                end else begin
                    checkOutput("beat_a", bus.a_o, beatq[0].a);
                    checkOutput("beat_b", bus.b_o, beatq[0].b);
                    checkOutput("beat_last", 64'(bus.last_o), 64'(beatq[0].last));
                    held      = bus.stall_i;
                    held_a    = bus.a_o;
                    held_b    = bus.b_o;
                    held_last = bus.last_o;
                    if (!bus.stall_i) begin
                        beat_t lb;
                        lb.a = bus.a_o;
                        lb.b = bus.b_o;
                        lb.last = bus.last_o;
                        beat_log.push_back(lb);
                        beat_cyc.push_back(cyc);
                        void'(beatq.pop_front());
                    end
                end
            end else begin
                checkOutput("last_without_valid", 64'(bus.last_o), 64'd0);
                held = 1'b0;
            end
        end
    end

    task automatic clearLogs();
        addr_log.delete();
        beat_log.delete();
        beat_cyc.delete();
    endtask

    task automatic applyStimulus(input logic [31:0] aa, input logic [31:0] sa,
                                 input logic [31:0] ab, input logic [31:0] sb,
                                 input int n, input bit lr);
        int start;
        int k;
        start = acc_count;
        bus.addr_a_i   = aa;
        bus.stride_a_i = sa;
        bus.addr_b_i   = ab;
        bus.stride_b_i = sb;
        bus.n_i        = 4'(n);
        bus.last_req_i = lr;
        bus.valid_i    = 1'b1;
        k = 0;
        while (acc_count == start && k < 200) begin
            step(1);
            k++;
        end
        bus.valid_i = 1'b0;
        if (acc_count == start) failNow("accept_timeout");
    endtask

    task automatic waitIdle(input int budget);
        int k;
        k = 0;
        while (!model_ready() && k < budget) begin
            step(1);
            k++;
        end
        if (!model_ready()) failNow("idle_timeout");
        step(1);
    endtask

    initial begin
        int lastCount;
        int k;
        bus.valid_i    = 1'b0;
        bus.addr_a_i   = 32'h1234;
        bus.addr_b_i   = 32'h5678;
        bus.stride_a_i = '0;
        bus.stride_b_i = '0;
        bus.n_i        = '0;
        bus.last_req_i = 1'b0;
        bus.stall_i    = 1'b0;
        rst            = 1'b1;
        step(3);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_ready", 64'(bus.ready_o), 64'd1);
        checkOutput("reset_valid", 64'(bus.valid_o), 64'd0);
        checkOutput("reset_busy", 64'(bus.busy_o), 64'd0);
        checkOutput("reset_en", 64'(bus.en_a_o), 64'd0);
        checkOutput("reset_a", bus.a_o, 64'd0);
        checkOutput("reset_addr_follow", 64'(bus.addr_a_o), 64'h1234);
        step(1);

        // Full unstalled tile with last_req.
        clearLogs();
        applyStimulus(32'h100, 32'd8, 32'h2000, 32'd16, 8, 1'b1);
        waitIdle(100);
        checkOutput("t8_addr_count", 64'(addr_log.size()), 64'd8);
        checkOutput("t8_beat_count", 64'(beat_log.size()), 64'd8);
        if (addr_log.size() == 8 && beat_log.size() == 8) begin
            checkOutput("t8_addr_first", 64'(addr_log[0]), 64'h100);
            checkOutput("t8_addr_last", 64'(addr_log[7]), 64'h138);
            checkOutput("t8_latency", 64'(beat_cyc[0] - acc_cyc), 64'd2);
            checkOutput("t8_contiguous", 64'(beat_cyc[7] - beat_cyc[0]), 64'd7);
            checkOutput("t8_last_on_8", 64'(beat_log[7].last), 64'd1);
            lastCount = 0;
            foreach (beat_log[i]) lastCount += int'(beat_log[i].last);
            checkOutput("t8_last_once", 64'(lastCount), 64'd1);
        end

        // Partial tile: only the first three lanes survive.
        ff_mode = 1'b1;
        clearLogs();
        applyStimulus(32'h400, 32'd8, 32'h800, 32'd8, 3, 1'b0);
        waitIdle(100);
        ff_mode = 1'b0;
        checkOutput("t3_beat_count", 64'(beat_log.size()), 64'd3);
        if (beat_log.size() == 3) begin
            checkOutput("t3_lanes_a", beat_log[0].a, 64'h0000_0000_00FF_FFFF);
            checkOutput("t3_lanes_b", beat_log[2].b, 64'h0000_0000_00FF_FFFF);
            checkOutput("t3_no_last", 64'(beat_log[2].last), 64'd0);
        end

        // Four-cycle stall once both output stage and skid hold rows.
        clearLogs();
        applyStimulus(32'h3000, 32'd64, 32'h7000, 32'd32, 8, 1'b1);
        step(2);
        bus.stall_i = 1'b1;
        step(4);
        bus.stall_i = 1'b0;
        waitIdle(100);
        checkOutput("stall_beat_count", 64'(beat_log.size()), 64'd8);
        if (beat_log.size() == 8)
            checkOutput("stall_span", 64'(beat_cyc[7] - beat_cyc[0]), 64'd11);

        // Reset while row 4 of 8 is in flight.
        clearLogs();
        applyStimulus(32'h9000, 32'd8, 32'hA000, 32'd8, 8, 1'b1);
        k = 0;
        while (addr_log.size() < 4 && k < 50) begin
            step(1);
            k++;
        end
        if (addr_log.size() < 4) failNow("row4_timeout");
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_valid", 64'(bus.valid_o), 64'd0);
        checkOutput("midrst_busy", 64'(bus.busy_o), 64'd0);
        checkOutput("midrst_ready", 64'(bus.ready_o), 64'd1);
        step(1);
        clearLogs();
        applyStimulus(32'hB000, 32'd8, 32'hC000, 32'd8, 5, 1'b1);
        waitIdle(100);
        checkOutput("postrst_beats", 64'(beat_log.size()), 64'd5);

        // n_i = 0 produces nothing; n_i = 15 clamps to eight rows.
        clearLogs();
        applyStimulus(32'hD000, 32'd8, 32'hE000, 32'd8, 0, 1'b1);
        step(4);
        checkOutput("n0_reads", 64'(addr_log.size()), 64'd0);
        checkOutput("n0_beats", 64'(beat_log.size()), 64'd0);
        checkOutput("n0_ready", 64'(bus.ready_o), 64'd1);
        clearLogs();
        applyStimulus(32'hD000, 32'd8, 32'hE000, 32'd8, 15, 1'b1);
        waitIdle(100);
        checkOutput("n15_beats", 64'(beat_log.size()), 64'd8);

        // Address wrap across 2^32.
        clearLogs();
        applyStimulus(32'hFFFF_FFF8, 32'd8, 32'hFFFF_FFF0, 32'd16, 2, 1'b0);
        waitIdle(100);
        checkOutput("wrap_count", 64'(addr_log.size()), 64'd2);
        if (addr_log.size() == 2)
            checkOutput("wrap_addr", 64'(addr_log[1]), 64'h0);

        // Random traffic, including requests offered while busy.
        for (int i = 0; i < 1500; i++) begin
            bus.valid_i    = ($urandom_range(0, 3) == 0);
            bus.addr_a_i   = $urandom;
            bus.addr_b_i   = $urandom;
            bus.stride_a_i = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 64));
            bus.stride_b_i = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 64));
            bus.n_i        = 4'($urandom_range(0, 15));
            bus.last_req_i = 1'($urandom_range(0, 1));
            bus.stall_i    = ($urandom_range(0, 3) == 0);
            step(1);
        end
        bus.valid_i = 1'b0;
        bus.stall_i = 1'b0;
        waitIdle(300);
        checkOutput("final_addrq_empty", 64'(addrq_a.size()), 64'd0);
        checkOutput("final_ready", 64'(bus.ready_o), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
